vga_frame_buffer: RTL and testbench
===================================

// Module: vga_frame_buffer
// PURPOSE
//  1-bit-per-pixel 256x128 frame buffer with colour-config register; sits directly upstream of the VGA signal generator.
//  Port A: req/ack read/write from the processor/bus side. Port B: read-only pixel fetch driven by the generator's address/enable.
//  Adds a hardware clear engine and a colour register that is updated only at frame start, to avoid tearing.
// PARAMETERS
//  ADDR_W        15        address width; depth = 2**ADDR_W (addr = {Y[6:0], X[7:0]})
//  RESET_COLOUR  16'hFF00  CONFIG_COLOURS after reset ([15:8] pixel=0 colour, [7:0] pixel=1 colour)
// PORTS
//  CLK             in   1       clock; all logic in this single domain
//  RESET           in   1       synchronous, active-high reset
//  A_REQ           in   1       port-A request; hold high until A_ACK
//  A_WE            in   1       1=write, 0=read; sampled with A_REQ
//  A_ADDR          in   ADDR_W  port-A address
//  A_DIN           in   1       write data
//  A_ACK           out  1       one-cycle completion pulse
//  A_DOUT          out  1       read data, valid in the A_ACK cycle
//  CLEAR_REQ       in   1       pulse: start fill of whole buffer
//  CLEAR_VAL       in   1       fill value, latched with CLEAR_REQ
//  BUSY            out  1       high while fill in progress
//  B_EN            in   1       pixel-clock enable (generator's DPR_CLK pulse)
//  B_ADDR          in   ADDR_W  pixel fetch address
//  B_DOUT          out  1       pixel data to generator
//  COLOUR_WE       in   1       load COLOUR_IN into pending register
//  COLOUR_IN       in   16      new colour pair
//  VSYNC           in   1       generator VS (active-low pulse)
//  CONFIG_COLOURS  out  16      live colour pair to generator
// BEHAVIOUR
//  Reset: A_ACK=0, A_DOUT=0, BUSY=0, B_DOUT=0, CONFIG_COLOURS=pending=RESET_COLOUR, FSM=IDLE. RAM contents not reset.
//  Port B: when B_EN=1, B_DOUT <= mem[B_ADDR] at that edge (1-CLK latency); holds otherwise. Always served, incl. during clear.
//  Read-during-write same address (A or clear write vs B read): B returns OLD data (read-first).
//  FSM states IDLE, ACCESS, CLEAR:
//   IDLE: CLEAR_REQ -> CLEAR (latch CLEAR_VAL, ptr=0, BUSY=1); else A_REQ -> ACCESS. CLEAR_REQ wins if both.
//   ACCESS: perform write (mem[A_ADDR]<=A_DIN) or read (A_DOUT<=mem[A_ADDR]); A_ACK=1 for exactly this cycle; -> IDLE.
//    So back-to-back held A_REQ gives one ACK every 2 cycles; min latency REQ->ACK = 1 cycle.
//   CLEAR: write latched value at ptr, ptr++ each cycle; at ptr=2**ADDR_W-1 write last, BUSY=0 next cycle, -> IDLE.
//    Clear takes exactly 2**ADDR_W cycles; A_REQ stalls (no ACK) and CLEAR_REQ is ignored while BUSY.
//  Colour: COLOUR_WE loads pending. On VSYNC falling edge (registered 1->0), CONFIG_COLOURS <= pending.
//   COLOUR_WE in same cycle as edge detect: new COLOUR_IN goes straight to CONFIG_COLOURS.
//  ptr is ADDR_W+0 bits; wrap to 0 is terminal condition, never a second pass.
//  RESET mid-clear or mid-access: abort immediately, partially cleared RAM remains; no ACK issued.
// STRUCTURE
//  Package vga_fb_pkg: FSM state enum (IDLE/ACCESS/CLEAR), DEFAULT_COLOUR constant, FB_ADDR_W=15.
//  Sub-module vga_fb_ram: simple dual-port RAM, port 1 write+read, port 2 read with enable, read-first, BRAM-inferable.
//  Top: FSM + clear pointer + port-A mux, VSYNC edge detector, colour pending/live registers.
// TESTING
//  1 Reset -> CONFIG_COLOURS=16'hFF00, BUSY=0, A_ACK=0; hold A_REQ during reset -> no ACK.
//  2 Write A_ADDR=15'h1234 A_DIN=1, then read same -> A_ACK 1 cycle after REQ, A_DOUT=1; B_EN with B_ADDR=15'h1234 -> B_DOUT=1 next cycle.
//  3 CLEAR_REQ, CLEAR_VAL=0 -> BUSY high 32768 cycles; A_REQ during clear ACKed only after BUSY falls; random B reads afterwards all 0.
//  4 CLEAR_REQ and A_REQ same cycle in IDLE -> clear starts, access completes after; second CLEAR_REQ while BUSY ignored (count stays 32768).
//  5 COLOUR_WE=16'h1CE0 mid-frame -> CONFIG_COLOURS unchanged until VSYNC 1->0, then 16'h1CE0; COLOUR_WE coincident with edge -> applied same edge.
//  6 Same-address clear write vs B read -> B_DOUT old value; RESET at ptr=100 -> BUSY=0 next cycle, addr 0..99 cleared, 100+ retain data.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the 1bpp VGA frame buffer.
// Imported by the frame buffer top and its RAM.
package vga_fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam logic [15:0] DEFAULT_COLOUR = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CLEAR
    } fb_state_e;

endpackage

// File: rtl/vga_fb_if.sv
// Port-A request/acknowledge bus of the frame buffer.
// The processor side is master; the frame buffer is slave.
interface vga_fb_if #(
    parameter int ADDR_W = 15
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              din;
    logic              ack;
    logic              dout;

    modport master (
        output req, we, addr, din,
        input  ack, dout
    );

    modport slave (
        input  req, we, addr, din,
        output ack, dout
    );

endinterface

// File: rtl/vga_fb_ram.sv
// Simple dual-port 1-bit RAM, read-first on both ports.
// Only the output registers are reset so the array maps to block RAM.
module vga_fb_ram #(
    parameter int ADDR_W = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we1,
    input  logic              re1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              din1,
    output logic              dout1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] addr2,
    output logic              dout2
);

    logic mem [0:(2**ADDR_W)-1];

    always_ff @(posedge CLK) begin
        if (we1) begin
            mem[addr1] <= din1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dout1 <= 1'b0;
        end else if (re1) begin
            dout1 <= mem[addr1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dout2 <= 1'b0;
        end else if (re2) begin
            dout2 <= mem[addr2];
        end
    end

endmodule

// File: rtl/vga_frame_buffer.sv
// 256x128 1bpp frame buffer: port-A access FSM, clear engine,
// pixel fetch port and tear-free colour register.
module vga_frame_buffer
    import vga_fb_pkg::*;
#(
    parameter int          ADDR_W       = FB_ADDR_W,
    parameter logic [15:0] RESET_COLOUR = DEFAULT_COLOUR
) (
    input  logic              CLK,
    input  logic              RESET,
    vga_fb_if.slave           a,
    input  logic              CLEAR_REQ,
    input  logic              CLEAR_VAL,
    output logic              BUSY,
    input  logic              B_EN,
    input  logic [ADDR_W-1:0] B_ADDR,
    output logic              B_DOUT,
    input  logic              COLOUR_WE,
    input  logic [15:0]       COLOUR_IN,
    input  logic              VSYNC,
    output logic [15:0]       CONFIG_COLOURS
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    fb_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic              clr_val;
    logic              ack_q;
    logic              port_act;
    logic              we1;
    logic              re1;
    logic [ADDR_W-1:0] addr1;
    logic              din1;
    logic              vs_q;
    logic              vs_fall;
    logic [15:0]       pending;

    // Port A is served on the edge that accepts the request,
    // so data and ACK appear together in the following cycle.
    always_comb begin
        port_act = 1'b0;
        we1      = 1'b0;
        re1      = 1'b0;
        addr1    = a.addr;
        din1     = a.din;
        if (!RESET) begin
            if (state == CLEAR) begin
                we1   = 1'b1;
                addr1 = ptr;
                din1  = clr_val;
            end else if (state == IDLE && !CLEAR_REQ) begin
                port_act = a.req;
                we1      = a.req & a.we;
                re1      = a.req & ~a.we;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            ptr     <= '0;
            clr_val <= 1'b0;
            ack_q   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (CLEAR_REQ) begin
                        state   <= CLEAR;
                        clr_val <= CLEAR_VAL;
                        ptr     <= '0;
                        BUSY    <= 1'b1;
                    end else if (port_act) begin
                        state <= ACCESS;
                        ack_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (ptr == PTR_MAX) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign a.ack = ack_q;

    vga_fb_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .RESET (RESET),
        .we1   (we1),
        .re1   (re1),
        .addr1 (addr1),
        .din1  (din1),
        .dout1 (a.dout),
        .re2   (B_EN),
        .addr2 (B_ADDR),
        .dout2 (B_DOUT)
    );

    assign vs_fall = vs_q & ~VSYNC;

    // Live colours only change at frame start to avoid tearing.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_q           <= 1'b0;
            pending        <= RESET_COLOUR;
            CONFIG_COLOURS <= RESET_COLOUR;
        end else begin
            vs_q <= VSYNC;
            if (COLOUR_WE) begin
                pending <= COLOUR_IN;
            end
            if (vs_fall) begin
                CONFIG_COLOURS <= COLOUR_WE ? COLOUR_IN : pending;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_vga_frame_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLEAR_REQ;
    logic        CLEAR_VAL;
    logic        BUSY;
    logic        B_EN;
    logic [14:0] B_ADDR;
    logic        B_DOUT;
    logic        COLOUR_WE;
    logic [15:0] COLOUR_IN;
    logic        VSYNC;
    logic [15:0] CONFIG_COLOURS;

    int ntest = 0;
    int nfail = 0;

    vga_fb_if #(.ADDR_W(15)) a_if ();

    vga_frame_buffer #(
        .ADDR_W       (15),
        .RESET_COLOUR (16'hFF00)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .a              (a_if),
        .CLEAR_REQ      (CLEAR_REQ),
        .CLEAR_VAL      (CLEAR_VAL),
        .BUSY           (BUSY),
        .B_EN           (B_EN),
        .B_ADDR         (B_ADDR),
        .B_DOUT         (B_DOUT),
        .COLOUR_WE      (COLOUR_WE),
        .COLOUR_IN      (COLOUR_IN),
        .VSYNC          (VSYNC),
        .CONFIG_COLOURS (CONFIG_COLOURS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_op(input logic        we,
                        input logic [14:0] addr,
                        input logic        din,
                        input logic        exp_dout,
                        input string       tag);
        int lat;
        a_if.req  = 1'b1;
        a_if.we   = we;
        a_if.addr = addr;
        a_if.din  = din;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!a_if.ack && lat < 8);
        chk({tag, "_lat"}, lat, 1);
        if (!we) chk({tag, "_dout"}, 32'(a_if.dout), 32'(exp_dout));
        a_if.req = 1'b0;
        tick();
        chk({tag, "_ackpulse"}, 32'(a_if.ack), 0);
    endtask

    task automatic b_rd(input logic [14:0] addr,
                        input logic        exp,
                        input string       tag);
        B_EN   = 1'b1;
        B_ADDR = addr;
        tick();
        B_EN = 1'b0;
        chk(tag, 32'(B_DOUT), 32'(exp));
    endtask

    initial begin
        int   cnt;
        int   guard;
        logic ack_in_busy;

        RESET     = 1'b1;
        a_if.req  = 1'b1;
        a_if.we   = 1'b1;
        a_if.addr = '0;
        a_if.din  = 1'b0;
        CLEAR_REQ = 1'b0;
        CLEAR_VAL = 1'b0;
        B_EN      = 1'b0;
        B_ADDR    = '0;
        COLOUR_WE = 1'b0;
        COLOUR_IN = '0;
        VSYNC     = 1'b1;

        // reset, with a request held throughout
        repeat (3) tick();
        chk("rst_ack", 32'(a_if.ack), 0);
        chk("rst_colour", 32'(CONFIG_COLOURS), 32'hFF00);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_adout", 32'(a_if.dout), 0);
        chk("rst_bdout", 32'(B_DOUT), 0);
        RESET    = 1'b0;
        a_if.req = 1'b0;
        tick();
        chk("rst_rel_ack", 32'(a_if.ack), 0);

        // port A write/read and port B fetch
        a_op(1'b1, 15'h1234, 1'b1, 1'b0, "wr1234");
        a_op(1'b0, 15'h1234, 1'b0, 1'b1, "rd1234");
        a_op(1'b1, 15'h1235, 1'b0, 1'b0, "wr1235");
        a_op(1'b0, 15'h1235, 1'b0, 1'b0, "rd1235");
        b_rd(15'h1234, 1'b1, "b1234");
        B_ADDR = 15'h1235;
        tick();
        chk("b_hold", 32'(B_DOUT), 1);
        b_rd(15'h1235, 1'b0, "b1235");

        // held request: one ACK every two cycles
        a_if.req  = 1'b1;
        a_if.we   = 1'b0;
        a_if.addr = 15'h1234;
        tick();
        chk("b2b_ack0", 32'(a_if.ack), 1);
        tick();
        chk("b2b_gap", 32'(a_if.ack), 0);
        tick();
        chk("b2b_ack1", 32'(a_if.ack), 1);
        a_if.req = 1'b0;
        tick();

        // colour register
        COLOUR_WE = 1'b1;
        COLOUR_IN = 16'h1CE0;
        tick();
        COLOUR_WE = 1'b0;
        chk("col_pend", 32'(CONFIG_COLOURS), 32'hFF00);
        tick();
        chk("col_wait", 32'(CONFIG_COLOURS), 32'hFF00);
        VSYNC = 1'b0;
        tick();
        chk("col_vs", 32'(CONFIG_COLOURS), 32'h1CE0);
        tick();
        chk("col_low", 32'(CONFIG_COLOURS), 32'h1CE0);
        VSYNC = 1'b1;
        tick();
        chk("col_rise", 32'(CONFIG_COLOURS), 32'h1CE0);
        COLOUR_WE = 1'b1;
        COLOUR_IN = 16'hABCD;
        VSYNC     = 1'b0;
        tick();
        COLOUR_WE = 1'b0;
        chk("col_coinc", 32'(CONFIG_COLOURS), 32'hABCD);
        VSYNC = 1'b1;
        COLOUR_WE = 1'b1;
        COLOUR_IN = 16'h5555;
        tick();
        COLOUR_WE = 1'b0;
        tick();
        chk("col_noedge", 32'(CONFIG_COLOURS), 32'hABCD);

        // full clear racing a port-A read
        a_op(1'b1, 15'h0000, 1'b1, 1'b0, "wr0000");
        CLEAR_REQ = 1'b1;
        CLEAR_VAL = 1'b0;
        a_if.req  = 1'b1;
        a_if.we   = 1'b0;
        a_if.addr = 15'h1234;
        B_EN      = 1'b1;
        B_ADDR    = 15'h0000;
        tick();
        CLEAR_REQ = 1'b0;
        chk("clr_busy", 32'(BUSY), 1);
        chk("clr_noack", 32'(a_if.ack), 0);
        cnt = 1;
        tick();
        chk("clr_rdfirst", 32'(B_DOUT), 1);
        if (BUSY) cnt++;
        tick();
        chk("clr_new", 32'(B_DOUT), 0);
        if (BUSY) cnt++;
        B_EN = 1'b0;
        ack_in_busy = 1'b0;
        guard = 0;
        while (BUSY && guard < 40000) begin
            if (guard == 10) begin
                CLEAR_REQ = 1'b1;
                CLEAR_VAL = 1'b1;
            end
            if (guard == 11) CLEAR_REQ = 1'b0;
            tick();
            guard++;
            if (a_if.ack) ack_in_busy = 1'b1;
            if (BUSY) cnt++;
        end
        chk("clr_timeout", 32'(BUSY), 0);
        chk("clr_cycles", cnt, 32768);
        chk("clr_stall", 32'(ack_in_busy), 0);
        tick();
        chk("clr_post_ack", 32'(a_if.ack), 1);
        chk("clr_post_dout", 32'(a_if.dout), 0);
        a_if.req = 1'b0;
        tick();
        b_rd(15'h0000, 1'b0, "clr_b0");
        b_rd(15'h7FFF, 1'b0, "clr_bmax");
        for (int i = 0; i < 6; i++) begin
            b_rd(15'($urandom), 1'b0, "clr_brand");
        end

        // reset part-way through a clear
        CLEAR_REQ = 1'b1;
        CLEAR_VAL = 1'b1;
        tick();
        CLEAR_REQ = 1'b0;
        chk("prt_busy", 32'(BUSY), 1);
        repeat (100) tick();
        RESET = 1'b1;
        tick();
        chk("prt_busy0", 32'(BUSY), 0);
        chk("prt_colour", 32'(CONFIG_COLOURS), 32'hFF00);
        RESET = 1'b0;
        tick();
        b_rd(15'd0, 1'b1, "prt_b0");
        b_rd(15'd50, 1'b1, "prt_b50");
        b_rd(15'd99, 1'b1, "prt_b99");
        b_rd(15'd100, 1'b0, "prt_b100");
        b_rd(15'd101, 1'b0, "prt_b101");
        b_rd(15'h7FFF, 1'b0, "prt_bmax");

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
